// File: rtl/div_arbiter_pkg.sv
// Shared definitions for the two-requester divider arbiter: default width,
// FSM state encoding and a small grant-encoding helper.
package div_arbiter_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    function automatic logic [1:0] id2onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/div_arbiter_if.sv
// Bundle of request, divider and response signals around div_arbiter.
// The arbiter uses the slave modport; the surrounding system uses master.
interface div_arbiter_if
    import div_arbiter_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);

    logic             req0_valid;
    logic             req1_valid;
    logic             req0_signed;
    logic             req1_signed;
    logic [WIDTH-1:0] req0_x;
    logic [WIDTH-1:0] req0_y;
    logic [WIDTH-1:0] req1_x;
    logic [WIDTH-1:0] req1_y;
    logic             req0_ready;
    logic             req1_ready;

    logic             flush;
    logic             flush_id;

    logic             dv_valid;
    logic             dv_ready;
    logic             dv_signed;
    logic [WIDTH-1:0] dv_x;
    logic [WIDTH-1:0] dv_y;
    logic             dv_done;
    logic [WIDTH-1:0] dv_s;
    logic [WIDTH-1:0] dv_r;

    logic             resp_valid;
    logic             resp_id;
    logic [WIDTH-1:0] resp_q;
    logic [WIDTH-1:0] resp_r;
    logic             resp_ready;

    modport master (
        output req0_valid, req1_valid, req0_signed, req1_signed,
        output req0_x, req0_y, req1_x, req1_y,
        input  req0_ready, req1_ready,
        output flush, flush_id,
        input  dv_valid, dv_signed, dv_x, dv_y,
        output dv_ready, dv_done, dv_s, dv_r,
        input  resp_valid, resp_id, resp_q, resp_r,
        output resp_ready
    );

    modport slave (
        input  req0_valid, req1_valid, req0_signed, req1_signed,
        input  req0_x, req0_y, req1_x, req1_y,
        output req0_ready, req1_ready,
        input  flush, flush_id,
        output dv_valid, dv_signed, dv_x, dv_y,
        input  dv_ready, dv_done, dv_s, dv_r,
        output resp_valid, resp_id, resp_q, resp_r,
        input  resp_ready
    );

endinterface

// File: rtl/div_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: the requester recorded as last served loses
// a tie. Priority only moves when the owner calls update_i.
module rr_arb2
    import div_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       update_i,
    input  logic       update_id_i,
    output logic [1:0] gnt_o
);

    logic lastGnt_q;
    logic lastGnt_d;

    // Reset as if requester 1 was served last so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (reset) begin
            lastGnt_q <= 1'b1;
        end else begin
            lastGnt_q <= lastGnt_d;
        end
    end

    always_comb begin
        lastGnt_d = lastGnt_q;
        if (update_i) begin
            lastGnt_d = update_id_i;
        end
    end

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = id2onehot(~lastGnt_q);
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Shares one multi-cycle divider between two requesters, one operation at a
// time, with per-owner flush and round-robin fairness on result consumption.
module div_arbiter
    import div_arbiter_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    div_arbiter_if.slave  bus
);

    arb_state_e       state_q, state_d;
    logic             owner_q, owner_d;
    logic             kill_q, kill_d;
    logic             signed_q, signed_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] resQ_q, resQ_d;
    logic [WIDTH-1:0] resR_q, resR_d;

    logic [1:0]       reqEff;
    logic [1:0]       gnt;
    logic             flushHit;
    logic             rrUpdate;

    // A flush aimed at a requester also masks that requester's new request.
    assign reqEff[0] = bus.req0_valid & ~(bus.flush & ~bus.flush_id);
    assign reqEff[1] = bus.req1_valid & ~(bus.flush &  bus.flush_id);
    assign flushHit  = bus.flush & (bus.flush_id == owner_q);

    rr_arb2 u_rr_arb2 (
        .clk         (clk),
        .reset       (reset),
        .req_i       (reqEff),
        .update_i    (rrUpdate),
        .update_id_i (owner_q),
        .gnt_o       (gnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            kill_q   <= 1'b0;
            signed_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            resQ_q   <= '0;
            resR_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            kill_q   <= kill_d;
            signed_q <= signed_d;
            x_q      <= x_d;
            y_q      <= y_d;
            resQ_q   <= resQ_d;
            resR_q   <= resR_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        kill_d   = kill_q;
        signed_d = signed_q;
        x_d      = x_q;
        y_d      = y_q;
        resQ_d   = resQ_q;
        resR_d   = resR_q;
        rrUpdate = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt != 2'b00) begin
                    owner_d  = gnt[1];
                    signed_d = gnt[1] ? bus.req1_signed : bus.req0_signed;
                    x_d      = gnt[1] ? bus.req1_x : bus.req0_x;
                    y_d      = gnt[1] ? bus.req1_y : bus.req0_y;
                    kill_d   = 1'b0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                // If the divider took the start as we were flushed, its
                // result still arrives and has to be swallowed in WAIT.
                if (flushHit && !bus.dv_ready) begin
                    state_d = IDLE;
                end else if (bus.dv_ready) begin
                    kill_d  = flushHit;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (flushHit) begin
                    kill_d = 1'b1;
                end
                if (bus.dv_done) begin
                    if (kill_q || flushHit) begin
                        kill_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        resQ_d  = bus.dv_s;
                        resR_d  = bus.dv_r;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (flushHit) begin
                    state_d = IDLE;
                end else if (bus.resp_ready) begin
                    rrUpdate = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.req0_ready = (state_q == IDLE) & gnt[0];
    assign bus.req1_ready = (state_q == IDLE) & gnt[1];

    assign bus.dv_valid   = (state_q == ISSUE);
    assign bus.dv_signed  = signed_q;
    assign bus.dv_x       = x_q;
    assign bus.dv_y       = y_q;

    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_id    = owner_q;
    assign bus.resp_q     = resQ_q;
    assign bus.resp_r     = resR_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter: the bench plays both requesters and the
// divider; expected results queue up and a negedge monitor retires them.
module tb_div_arbiter;
    import div_arbiter_pkg::*;

    localparam int W = DIV_WIDTH;

    typedef struct packed {
        logic         id;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } resp_t;

    logic  clk = 1'b0;
    logic  reset;
    int    checks = 0;
    int    errors = 0;
    resp_t sbQueue[$];

    div_arbiter_if #(.WIDTH(W)) bus ();

    div_arbiter #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: handshake never arrived within budget", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Retire one expected result per response handshake.
    always @(negedge clk) begin : monitor
        resp_t e;
        if (!reset && bus.resp_valid === 1'b1 && bus.resp_ready === 1'b1) begin
            if (sbQueue.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_resp: got id %0d q %0h r %0h, expected no response",
                         bus.resp_id, bus.resp_q, bus.resp_r);
            end else begin
                e = sbQueue.pop_front();
                checkOutput("resp_id", {63'd0, bus.resp_id}, {63'd0, e.id});
                checkOutput("resp_q", {32'd0, bus.resp_q}, {32'd0, e.q});
                checkOutput("resp_r", {32'd0, bus.resp_r}, {32'd0, e.r});
            end
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_req0_ready"}, bus.req0_ready, 0);
        checkOutput({tag, "_req1_ready"}, bus.req1_ready, 0);
        checkOutput({tag, "_dv_valid"}, bus.dv_valid, 0);
        checkOutput({tag, "_resp_valid"}, bus.resp_valid, 0);
        checkOutput({tag, "_resp_id"}, bus.resp_id, 0);
        checkOutput({tag, "_resp_q"}, bus.resp_q, 0);
        checkOutput({tag, "_resp_r"}, bus.resp_r, 0);
        checkOutput({tag, "_dv_x"}, bus.dv_x, 0);
        checkOutput({tag, "_dv_y"}, bus.dv_y, 0);
        checkOutput({tag, "_dv_signed"}, bus.dv_signed, 0);
    endtask

    // Present a request, wait for acceptance, then confirm dv_valid next cycle.
    task automatic applyStimulus(input logic id, input logic sgn,
                                 input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic wantResp,
                                 input logic [W-1:0] eq, input logic [W-1:0] er);
        bit accepted = 0;
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_signed = sgn; bus.req1_x = x; bus.req1_y = y;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_signed = sgn; bus.req0_x = x; bus.req0_y = y;
        end
        for (int i = 0; i < 20 && !accepted; i++) begin
            #1;
            if ((id ? bus.req1_ready : bus.req0_ready) === 1'b1) accepted = 1;
            tick();
        end
        if (id) bus.req1_valid = 1'b0;
        else    bus.req0_valid = 1'b0;
        if (!accepted) begin
            timeoutFail("req_accept_timeout");
        end else begin
            checkOutput("dv_valid_latency", bus.dv_valid, 1);
            if (wantResp) sbQueue.push_back('{id: id, q: eq, r: er});
        end
    endtask

    // Act as the divider. mode 0: complete; 1: flush owner fid in WAIT;
    // 2: stop right after the start is accepted.
    task automatic serveDivider(input logic [W-1:0] ex, input logic [W-1:0] ey,
                                input logic es, input int readyDelay,
                                input int mode, input logic fid,
                                input logic [W-1:0] q, input logic [W-1:0] r);
        int n = 0;
        while (bus.dv_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (bus.dv_valid !== 1'b1) begin
            timeoutFail("dv_valid_timeout");
            return;
        end
        for (int i = 0; i <= readyDelay; i++) begin
            checkOutput("dv_valid_hold", bus.dv_valid, 1);
            checkOutput("dv_x", bus.dv_x, ex);
            checkOutput("dv_y", bus.dv_y, ey);
            checkOutput("dv_signed", bus.dv_signed, es);
            if (i < readyDelay) tick();
        end
        // A stray done during the acceptance cycle must be ignored.
        bus.dv_ready = 1'b1; bus.dv_done = 1'b1; bus.dv_s = 32'hDEADBEEF; bus.dv_r = 32'hDEADBEEF;
        tick();
        bus.dv_ready = 1'b0; bus.dv_done = 1'b0; bus.dv_s = '0; bus.dv_r = '0;
        if (mode == 2) return;
        if (mode == 1) begin
            bus.flush = 1'b1; bus.flush_id = fid;
            tick();
            bus.flush = 1'b0;
        end
        tick();
        bus.dv_done = 1'b1; bus.dv_s = q; bus.dv_r = r;
        @(negedge clk);
        checkOutput("resp_not_early", bus.resp_valid, 0);
        tick();
        bus.dv_done = 1'b0; bus.dv_s = '0; bus.dv_r = '0;
    endtask

    task automatic finishResp();
        int n = 0;
        while (bus.resp_valid === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("resp_drained", bus.resp_valid, 0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        bus.req0_valid = 0; bus.req1_valid = 0; bus.req0_signed = 0; bus.req1_signed = 0;
        bus.req0_x = '0; bus.req0_y = '0; bus.req1_x = '0; bus.req1_y = '0;
        bus.flush = 0; bus.flush_id = 0; bus.dv_ready = 0; bus.dv_done = 0;
        bus.dv_s = '0; bus.dv_r = '0; bus.resp_ready = 1;
        doReset();
        checkAllZero("reset");

        // 100 / 7 signed from requester 0
        applyStimulus(0, 1, 100, 7, 1, 14, 2);
        serveDivider(100, 7, 1, 0, 0, 0, 14, 2);
        checkOutput("resp_valid_after_done", bus.resp_valid, 1);
        finishResp();

        // Contention from reset: 0, then 1, then 0 again, then 1
        doReset();
        bus.req1_valid = 1; bus.req1_signed = 0; bus.req1_x = 45; bus.req1_y = 4;
        bus.req0_valid = 1; bus.req0_signed = 0; bus.req0_x = 20; bus.req0_y = 6;
        #1;
        checkOutput("rr_first_req0_ready", bus.req0_ready, 1);
        checkOutput("rr_first_req1_ready", bus.req1_ready, 0);
        applyStimulus(0, 0, 20, 6, 1, 3, 2);
        checkOutput("busy_req1_ready", bus.req1_ready, 0);
        serveDivider(20, 6, 0, 0, 0, 0, 3, 2);
        finishResp();
        applyStimulus(1, 0, 45, 4, 1, 11, 1);
        serveDivider(45, 4, 0, 0, 0, 0, 11, 1);
        bus.req0_valid = 1; bus.req0_signed = 0; bus.req0_x = 9;  bus.req0_y = 3;
        bus.req1_valid = 1; bus.req1_signed = 0; bus.req1_x = 50; bus.req1_y = 5;
        finishResp();
        #1;
        checkOutput("rr_again_req0_ready", bus.req0_ready, 1);
        checkOutput("rr_again_req1_ready", bus.req1_ready, 0);
        applyStimulus(0, 0, 9, 3, 1, 3, 0);
        serveDivider(9, 3, 0, 0, 0, 0, 3, 0);
        finishResp();
        applyStimulus(1, 0, 50, 5, 1, 10, 0);
        serveDivider(50, 5, 0, 0, 0, 0, 10, 0);
        finishResp();

        // -7 / 2 signed from requester 1, flushed while waiting
        applyStimulus(1, 1, 32'hFFFF_FFF9, 2, 0, 0, 0);
        serveDivider(32'hFFFF_FFF9, 2, 1, 0, 1, 1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        checkOutput("kill_no_resp", bus.resp_valid, 0);
        bus.req0_valid = 1; bus.req0_signed = 1; bus.req0_x = 32'hFFFF_FF9C; bus.req0_y = 7;
        #1;
        checkOutput("idle_after_kill", bus.req0_ready, 1);
        applyStimulus(0, 1, 32'hFFFF_FF9C, 7, 1, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
        serveDivider(32'hFFFF_FF9C, 7, 1, 5, 0, 0, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
        finishResp();

        // Flush in ISSUE: wrong id ignored, owner id returns to IDLE
        applyStimulus(0, 0, 5, 1, 0, 0, 0);
        bus.flush = 1; bus.flush_id = 1;
        tick();
        checkOutput("flush_other_dv_valid", bus.dv_valid, 1);
        bus.flush_id = 0;
        tick();
        bus.flush = 0;
        checkOutput("flush_issue_dv_valid", bus.dv_valid, 0);

        // Flush in IDLE suppresses the matching acceptance
        bus.req0_valid = 1; bus.req0_signed = 0; bus.req0_x = 8; bus.req0_y = 2;
        bus.flush = 1; bus.flush_id = 0;
        #1;
        checkOutput("flush_suppress_ready", bus.req0_ready, 0);
        bus.flush = 0;

        // Flush in RESP drops the held result
        bus.resp_ready = 0;
        applyStimulus(0, 0, 8, 2, 0, 0, 0);
        serveDivider(8, 2, 0, 0, 0, 0, 4, 0);
        checkOutput("resp_held_before_flush", bus.resp_valid, 1);
        bus.flush = 1; bus.flush_id = 0;
        tick();
        bus.flush = 0;
        checkOutput("flush_resp_drop", bus.resp_valid, 0);

        // Back-pressure on the response, then a divide-by-zero forwarded
        applyStimulus(0, 0, 1000, 33, 1, 30, 10);
        serveDivider(1000, 33, 0, 0, 0, 0, 30, 10);
        bus.req1_valid = 1; bus.req1_signed = 0; bus.req1_x = 7; bus.req1_y = 0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp_resp_valid", bus.resp_valid, 1);
            checkOutput("bp_resp_q", bus.resp_q, 30);
            checkOutput("bp_resp_r", bus.resp_r, 10);
            checkOutput("bp_req0_ready", bus.req0_ready, 0);
            checkOutput("bp_req1_ready", bus.req1_ready, 0);
            tick();
        end
        bus.resp_ready = 1;
        tick();
        #1;
        checkOutput("req_after_consume", bus.req1_ready, 1);
        applyStimulus(1, 0, 7, 0, 1, 32'hFFFF_FFFF, 7);
        serveDivider(7, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 7);
        finishResp();

        // Reset while waiting; the late done must be ignored
        applyStimulus(0, 1, 100, 7, 0, 0, 0);
        serveDivider(100, 7, 1, 0, 2, 0, 0, 0);
        tick();
        reset = 1;
        tick();
        reset = 0;
        bus.dv_done = 1; bus.dv_s = 14; bus.dv_r = 2;
        tick();
        bus.dv_done = 0; bus.dv_s = '0; bus.dv_r = '0;
        tick();
        checkAllZero("midreset");

        checkOutput("scoreboard_empty", sbQueue.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req0_valid, req1_valid  in  1 each  requester n presents a divide.
REQ-005 req0_signed, req1_signed  in  1 each  1 = signed, 0 = unsigned.
REQ-006 req0_x, req0_y, req1_x, req1_y  in  WIDTH each  dividend and divisor.
REQ-007 req0_ready, req1_ready  out  1 each  request accepted this cycle when valid&ready.
REQ-008 flush  in  1  cancel the operation owned by requester flush_id.
REQ-009 flush_id  in  1  requester being flushed.
REQ-010 dv_valid  out  1  start strobe to the shared divider.
REQ-011 dv_ready  in  1  divider accepts the start this cycle.
REQ-012 dv_signed  out  1  signedness to the divider.
REQ-013 dv_x, dv_y  out  WIDTH each  operands to the divider.
REQ-014 dv_done  in  1  divider result valid; meaningful only in WAIT.
REQ-015 dv_s, dv_r  in  WIDTH each  quotient and remainder from the divider.
REQ-016 resp_valid  out  1  result held for owner.
REQ-017 resp_id  out  1  owner of the result.
REQ-018 resp_q, resp_r  out  WIDTH each  quotient and remainder.
REQ-019 resp_ready  in  1  owner consumes result when resp_valid&resp_ready.

Function
REQ-020 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-021 IDLE: req_ready SHALL be high only for the granted requester; grant is round-robin, the last-served requester having lower priority; after reset requester 0 has priority.
REQ-022 IDLE with an accepted request SHALL latch operands, signedness and owner id, then move to ISSUE next cycle; no request SHALL leave the FSM in IDLE.
REQ-023 ISSUE: dv_valid SHALL be high with the latched operands; dv_valid&dv_ready SHALL move to WAIT; dv_valid and dv_x/dv_y/dv_signed SHALL be stable until accepted.
REQ-024 WAIT: dv_done SHALL be ignored in the acceptance cycle and sampled from the following cycle; dv_done SHALL capture dv_s/dv_r into result registers and move to RESP.
REQ-025 RESP: resp_valid SHALL be high with resp_id = owner; results SHALL hold stable until resp_ready; resp_valid&resp_ready SHALL return to IDLE and update round-robin priority.
REQ-026 Issue latency: request accepted in cycle N -> dv_valid in N+1; result visible no earlier than one cycle after dv_done.
REQ-027 flush matching the owner in ISSUE SHALL return to IDLE without driving dv_valid further.
REQ-028 flush matching the owner in WAIT SHALL set a kill flag; on dv_done the result SHALL be discarded and the FSM SHALL return to IDLE with no resp_valid.
REQ-029 flush matching the owner in RESP SHALL drop resp_valid next cycle and return to IDLE.
REQ-030 flush with a non-matching flush_id, or in IDLE, SHALL have no effect.
REQ-031 flush in the same cycle as an IDLE acceptance for the same id SHALL suppress that acceptance (req_ready low for that id).
REQ-032 At most one operation SHALL be outstanding; both req_ready SHALL be low outside IDLE.
REQ-033 Divide-by-zero SHALL be forwarded unchanged; the arbiter SHALL NOT interpret operands.

Reset
REQ-034 reset SHALL force IDLE, clear the kill flag, set priority to requester 0, and zero all result/operand registers.
REQ-035 After reset: req0_ready=0, req1_ready=0, dv_valid=0, resp_valid=0, resp_id=0, resp_q=0, resp_r=0, dv_x=0, dv_y=0, dv_signed=0.
REQ-036 reset mid-operation SHALL abandon the operation; any later dv_done SHALL be ignored while in IDLE.

Structure
REQ-037 FSM state encoding and the WIDTH default SHALL live in the shared cpu package.
REQ-038 Round-robin grant logic SHALL be a sub-module rr_arb2 (two requests, last-grant register, one-hot grant).

Verification
REQ-039 Single req0 x=100, y=7 signed -> dv_valid the cycle after acceptance; resp_id=0, resp_q=14, resp_r=2.
REQ-040 req0 and req1 valid together from reset -> req0 served first, then req1; the next contention goes to req0 again only after req1 is served.
REQ-041 req1 x=-7, y=2 signed; flush flush_id=1 in WAIT -> no resp_valid; IDLE after dv_done; req0 accepted next.
REQ-042 dv_ready held low 5 cycles in ISSUE -> dv_x/dv_y/dv_signed stable, dv_valid high throughout.
REQ-043 resp_ready low 3 cycles in RESP -> resp_q/resp_r stable; req_ready both low; req accepted the cycle after consumption.
REQ-044 reset asserted in WAIT, then dv_done pulses -> all outputs 0, no resp_valid.
